// File: rtl/lsu_pkg.sv
// Shared load/store types: FSM states and the access-size encodings used by the decoder.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_t;

  localparam logic [1:0] LT_LB = 2'd0;
  localparam logic [1:0] LT_LH = 2'd1;
  localparam logic [1:0] LT_LW = 2'd2;
  localparam logic [1:0] ST_SB = 2'd0;
  localparam logic [1:0] ST_SH = 2'd1;
  localparam logic [1:0] ST_SW = 2'd2;

  // Encoding 11 behaves as a full word for both loads and stores.
  function automatic logic [1:0] norm_size(input logic [1:0] t);
    return (t == 2'b11) ? LT_LW : t;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      LT_LB:   return 1'b0;
      LT_LH:   return lane[0];
      default: return |lane;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and lane extraction with sign extension for loads.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_lane,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_lane,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    case (st_size)
      ST_SB: begin
        st_be    = 4'b0001 << st_lane;
        st_wdata = {4{st_data[7:0]}};
      end
      ST_SH: begin
        st_be    = st_lane[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{st_data[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = st_data;
      end
    endcase
  end

  always_comb begin
    ld_byte = ld_word[{ld_lane, 3'b000} +: 8];
    ld_half = ld_lane[1] ? ld_word[31:16] : ld_word[15:0];
    case (ld_size)
      LT_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
      LT_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
      default: ld_data = ld_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: one req/gnt/rvalid transaction per access, with
// pipeline stall, misalignment drop and timeout abort.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  l_type,
  input  logic [1:0]  s_type,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        load_valid,
  output logic [31:0] load_data,
  output logic        misalign_err,
  output logic        bus_err,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  lsu_state_t  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic        req_q, req_d;
  logic        busy_q, busy_d;
  logic        load_valid_q, load_valid_d;
  logic        bus_err_q, bus_err_d;
  logic [31:0] load_data_q, load_data_d;

  logic        op, op_we, op_mis, abort;
  logic [1:0]  op_size;
  logic [3:0]  st_be;
  logic [31:0] st_wdata, ld_ext;

  // A store wins when both controls are raised.
  always_comb begin
    op      = mem_read | mem_write;
    op_we   = mem_write;
    op_size = norm_size(op_we ? s_type : l_type);
    op_mis  = is_misaligned(op_size, addr[1:0]);
  end

  lsu_align u_align (
    .st_size  (op_size),
    .st_lane  (addr[1:0]),
    .st_data  (wdata),
    .st_be    (st_be),
    .st_wdata (st_wdata),
    .ld_size  (size_q),
    .ld_lane  (addr_q[1:0]),
    .ld_word  (dmem_rdata),
    .ld_data  (ld_ext)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = '0;
    addr_d       = addr_q;
    size_d       = size_q;
    we_d         = we_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    req_d        = req_q;
    busy_d       = busy_q;
    load_valid_d = 1'b0;
    bus_err_d    = 1'b0;
    load_data_d  = load_data_q;
    abort        = 1'b0;
    case (state_q)
      IDLE: begin
        if (op && !op_mis) begin
          addr_d  = addr;
          size_d  = op_size;
          we_d    = op_we;
          be_d    = op_we ? st_be : 4'hF;
          wdata_d = st_wdata;
          req_d   = 1'b1;
          busy_d  = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (dmem_gnt && we_q) begin
          req_d   = 1'b0;
          busy_d  = 1'b0;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          abort = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (dmem_gnt) begin
            req_d   = 1'b0;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (dmem_rvalid) begin
          load_data_d  = ld_ext;
          load_valid_d = 1'b1;
          busy_d       = 1'b0;
          state_d      = DONE;
        end else if (cnt_q == CNT_LAST) begin
          abort = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // A timed-out load still completes towards MEM/WB, with zero data.
    if (abort) begin
      req_d        = 1'b0;
      busy_d       = 1'b0;
      bus_err_d    = 1'b1;
      load_valid_d = !we_q;
      load_data_d  = '0;
      state_d      = DONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      size_q       <= '0;
      we_q         <= 1'b0;
      be_q         <= '0;
      wdata_q      <= '0;
      req_q        <= 1'b0;
      busy_q       <= 1'b0;
      load_valid_q <= 1'b0;
      bus_err_q    <= 1'b0;
      load_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      we_q         <= we_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
      req_q        <= req_d;
      busy_q       <= busy_d;
      load_valid_q <= load_valid_d;
      bus_err_q    <= bus_err_d;
      load_data_q  <= load_data_d;
    end
  end

  assign stall        = busy_q | ((state_q == IDLE) && op && !op_mis && !rst);
  assign misalign_err = (state_q == IDLE) && op && op_mis && !rst;
  assign dmem_req     = req_q;
  assign dmem_we      = we_q;
  assign dmem_addr    = {addr_q[31:2], 2'b00};
  assign dmem_be      = be_q;
  assign dmem_wdata   = wdata_q;
  assign load_valid   = load_valid_q;
  assign bus_err      = bus_err_q;
  assign load_data    = load_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit: per-transaction timeline model plus directed cases.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_read = 0, mem_write = 0;
  logic [1:0]  l_type = 0, s_type = 0;
  logic [31:0] addr = 0, wdata = 0;
  logic        stall, load_valid, misalign_err, bus_err;
  logic [31:0] load_data;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt = 0, dmem_rvalid = 0;
  logic [31:0] dmem_rdata = 0;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .l_type(l_type), .s_type(s_type), .addr(addr), .wdata(wdata),
    .stall(stall), .load_valid(load_valid), .load_data(load_data),
    .misalign_err(misalign_err), .bus_err(bus_err),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
  );

  int checks = 0;
  int errors = 0;

  // Expected outputs for the current cycle, set by the stimulus thread.
  logic        chk_en = 0;
  logic        x_stall, x_req, x_lv, x_mis, x_berr, x_we, x_chkwd;
  logic [31:0] x_ld, x_addr, x_wd;
  logic [3:0]  x_be;

  logic [31:0] obs_wd, obs_ld;
  logic [3:0]  obs_be;
  int          stall_cnt, req_cnt, lv_cnt;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic clear_exp();
    x_stall = 0; x_req = 0; x_lv = 0; x_mis = 0; x_berr = 0; x_we = 0; x_chkwd = 0;
    x_ld = 0; x_addr = 0; x_wd = 0; x_be = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single compare process, mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("stall", {31'd0, stall}, {31'd0, x_stall});
      cmp("dmem_req", {31'd0, dmem_req}, {31'd0, x_req});
      cmp("load_valid", {31'd0, load_valid}, {31'd0, x_lv});
      cmp("misalign_err", {31'd0, misalign_err}, {31'd0, x_mis});
      cmp("bus_err", {31'd0, bus_err}, {31'd0, x_berr});
      if (x_req) begin
        cmp("dmem_addr", dmem_addr, x_addr);
        cmp("dmem_be", {28'd0, dmem_be}, {28'd0, x_be});
        cmp("dmem_we", {31'd0, dmem_we}, {31'd0, x_we});
        if (x_chkwd) cmp("dmem_wdata", dmem_wdata, x_wd);
        obs_be = dmem_be;
        obs_wd = dmem_wdata;
      end
      if (x_lv) begin
        cmp("load_data", load_data, x_ld);
        obs_ld = load_data;
      end
      if (stall) stall_cnt++;
      if (dmem_req) req_cnt++;
      if (load_valid) lv_cnt++;
    end
  end

  // ---- behavioural model: byte arithmetic on access size and lane ----
  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic m_mis(input logic [1:0] sz, input logic [1:0] a);
    return (int'(a) % nbytes(sz)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [1:0] a);
    logic [3:0] r;
    int n = nbytes(sz);
    for (int i = 0; i < 4; i++) r[i] = (i >= int'(a)) && (i < int'(a) + n);
    return r;
  endfunction

  function automatic logic [31:0] m_wd(input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] r;
    int n = nbytes(sz);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_ld(input logic [1:0] sz, input logic [1:0] a, input logic [31:0] w);
    logic [31:0] v, mask;
    int n = nbytes(sz);
    if (n == 4) return w;
    v = w >> (8 * int'(a));
    mask = (n == 1) ? 32'h0000_00FF : 32'h0000_FFFF;
    v = v & mask;
    if (v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  // One access: g = REQ cycles before gnt, r = WAIT cycles up to and including rvalid.
  task automatic run_op(input logic we, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] d, input int g, input int r, input logic [31:0] rd);
    logic ok;
    int rq, wt;
    mem_write = we;
    mem_read  = we ? logic'($urandom % 2) : 1'b1;
    if (we) begin s_type = sz; l_type = 2'($urandom); end
    else    begin l_type = sz; s_type = 2'($urandom); end
    addr = a; wdata = d;
    dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = $urandom;
    clear_exp();
    if (m_mis(sz, a[1:0])) begin
      x_mis = 1;
      tick();
      mem_read = 0; mem_write = 0;
      clear_exp();
      return;
    end
    x_stall = 1;
    tick();
    if (we) begin
      ok = (g < TO);
      rq = ok ? g + 1 : TO;
      wt = 0;
    end else begin
      ok = (g + 1 + r) <= TO;
      rq = (g + 1 < TO) ? g + 1 : TO;
      wt = ok ? r : TO - rq;
    end
    x_stall = 1; x_req = 1; x_addr = {a[31:2], 2'b00}; x_we = we;
    x_be = we ? m_be(sz, a[1:0]) : 4'hF;
    x_wd = m_wd(sz, d); x_chkwd = we;
    for (int k = 0; k < rq; k++) begin
      dmem_gnt = (k == g);
      dmem_rdata = $urandom;
      addr = $urandom; wdata = $urandom;
      tick();
    end
    dmem_gnt = 0;
    clear_exp();
    x_stall = 1;
    for (int k = 0; k < wt; k++) begin
      dmem_rvalid = ok && (k == wt - 1);
      dmem_rdata  = dmem_rvalid ? rd : $urandom;
      tick();
    end
    dmem_rvalid = 0;
    clear_exp();
    x_lv = !we; x_berr = !ok;
    x_ld = ok ? m_ld(sz, a[1:0], rd) : 32'd0;
    mem_read = logic'($urandom % 2); mem_write = logic'($urandom % 2);
    addr = $urandom;
    tick();
    mem_read = 0; mem_write = 0;
    clear_exp();
  endtask

  task automatic reset_mid(input logic in_wait);
    mem_read = 1; mem_write = 0; l_type = LT_LW; addr = 32'h200;
    dmem_gnt = 0; dmem_rvalid = 0;
    clear_exp(); x_stall = 1;
    tick();
    x_req = 1; x_addr = 32'h200; x_be = 4'hF; x_we = 0;
    dmem_gnt = in_wait;
    tick();
    dmem_gnt = 0;
    #2;
    chk_en = 0;
    mem_read = 0;
    rst = 1;
    #1;
    cmp("rst_mid_stall", {31'd0, stall}, 32'd0);
    cmp("rst_mid_req", {31'd0, dmem_req}, 32'd0);
    cmp("rst_mid_lv", {31'd0, load_valid}, 32'd0);
    @(posedge clk); #1;
    rst = 0;
    clear_exp();
    chk_en = 1;
    lv_cnt = 0;
    tick();
    dmem_rvalid = 1; dmem_rdata = 32'hCAFE_F00D;
    tick();
    dmem_rvalid = 0;
    tick(); tick();
    cmp("rst_late_rvalid_lv", lv_cnt, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic we;
    logic [1:0] sz;
    logic [31:0] a;
    int g, r, kind;

    // Reset held with an aligned op presented: everything must stay 0.
    clear_exp();
    mem_read = 1; l_type = LT_LW; addr = 32'h40;
    chk_en = 1;
    repeat (3) tick();
    cmp("rst_load_data", load_data, 32'd0);
    cmp("rst_dmem_addr", dmem_addr, 32'd0);
    cmp("rst_dmem_be", {28'd0, dmem_be}, 32'd0);
    cmp("rst_dmem_wdata", dmem_wdata, 32'd0);
    mem_read = 0;
    rst = 0;
    tick();

    // Hand-computed pins for the model itself.
    cmp("model_lb", m_ld(LT_LB, 2'd2, 32'h12F45678), 32'hFFFF_FFF4);
    cmp("model_lh", m_ld(LT_LH, 2'd2, 32'h12F45678), 32'h0000_12F4);
    cmp("model_sb_be", {28'd0, m_be(ST_SB, 2'd3)}, 32'h8);
    cmp("model_sh_wd", m_wd(ST_SH, 32'h1234), 32'h1234_1234);

    // Directed cases.
    stall_cnt = 0;
    run_op(1, ST_SW, 32'h100, 32'hDEADBEEF, 0, 1, 0);
    cmp("sw_stall_cycles", stall_cnt, 2);
    cmp("sw_be", {28'd0, obs_be}, 32'hF);
    cmp("sw_wdata", obs_wd, 32'hDEADBEEF);

    run_op(1, ST_SB, 32'h103, 32'h000000A5, 0, 1, 0);
    cmp("sb_be", {28'd0, obs_be}, 32'h8);
    cmp("sb_wdata", obs_wd, 32'hA5A5A5A5);

    run_op(1, ST_SH, 32'h102, 32'h00001234, 1, 1, 0);
    cmp("sh_be", {28'd0, obs_be}, 32'hC);
    cmp("sh_wdata", obs_wd, 32'h12341234);

    run_op(0, LT_LB, 32'h102, 0, 0, 1, 32'h12F45678);
    cmp("lb_data", obs_ld, 32'hFFFFFFF4);
    run_op(0, LT_LH, 32'h102, 0, 0, 2, 32'h12F45678);
    cmp("lh_data", obs_ld, 32'h000012F4);

    stall_cnt = 0; lv_cnt = 0;
    run_op(0, LT_LW, 32'h100, 0, 0, 1, 32'h12F45678);
    cmp("lw_data", obs_ld, 32'h12F45678);
    cmp("lw_stall_cycles", stall_cnt, 3);
    cmp("lw_valid_pulses", lv_cnt, 1);

    stall_cnt = 0; req_cnt = 0;
    run_op(0, LT_LW, 32'h0FE, 0, 0, 1, 0);
    tick();
    cmp("mis_stall_cycles", stall_cnt, 0);
    cmp("mis_req_cycles", req_cnt, 0);

    stall_cnt = 0; lv_cnt = 0;
    run_op(0, LT_LW, 32'h300, 0, 100, 1, 32'h1111_1111);
    cmp("timeout_stall_cycles", stall_cnt, 1 + TO);
    cmp("timeout_valid_pulses", lv_cnt, 1);

    reset_mid(1'b1);
    reset_mid(1'b0);

    // Randomized traffic.
    for (int it = 0; it < 300; it++) begin
      kind = $urandom % 10;
      if (kind == 0) begin
        mem_read = 0; mem_write = 0;
        dmem_gnt = logic'($urandom % 2); dmem_rvalid = logic'($urandom % 2);
        clear_exp();
        tick();
        dmem_gnt = 0; dmem_rvalid = 0;
      end else begin
        we = logic'($urandom % 2);
        sz = 2'($urandom);
        a  = $urandom;
        if ($urandom % 4 != 0) a = a & ~(32'(nbytes(sz)) - 32'd1);
        g = ($urandom % 8 != 0) ? int'($urandom % 3) : 12 + int'($urandom % 10);
        r = ($urandom % 8 != 0) ? 1 + int'($urandom % 3) : 8 + int'($urandom % 12);
        run_op(we, sz, a, $urandom, g, r, $urandom);
      end
    end

    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
